// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t : FSM state encodings (IDLE / ADD / DONE)
//   G, H    : carry-state constants of the one-bit Mealy adder
//             (G = no carry pending, H = carry pending)
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic G = 1'b0;
    localparam logic H = 1'b1;

endpackage

// File: rtl/serial_add_cell.sv
// ---------------------------------------------------------------------------
// serial_add_cell
// One-bit Mealy adder. The carry flip-flop is the machine's state (G/H),
// and the sum bit is a combinational function of the inputs and that state.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset   : synchronous active-high reset, carry -> G
//   i_a, i_b  : current operand bits
//   i_clear   : force carry to G (start of a new addition)
//   i_enable  : advance the carry state by one bit
//   o_s       : sum bit for the current inputs and carry
//   o_carry   : current carry state
// ---------------------------------------------------------------------------
module serial_add_cell
    import serial_add_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_a,
    input  logic i_b,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_s,
    output logic o_carry
);

    logic r_carry;
    logic w_majority;

    assign o_s        = i_a ^ i_b ^ r_carry;
    assign w_majority = (i_a & i_b) | (i_a & r_carry) | (i_b & r_carry);
    assign o_carry    = r_carry;

    // Carry state: reset and clear both return to G; clear wins over enable
    // so a new addition always starts from a clean carry.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_carry <= G;
        end else if (i_clear) begin
            r_carry <= G;
        end else if (i_enable) begin
            r_carry <= w_majority ? H : G;
        end
    end

endmodule

// File: rtl/serial_add_controller.sv
// ---------------------------------------------------------------------------
// serial_add_controller
// Adds two N-bit operands one bit per cycle, LSB first, using a single
// serial_add_cell. An accepted start takes N ADD cycles plus one DONE cycle.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_start   : add request, only looked at in IDLE
//   i_a, i_b  : operands, captured on the accepting edge
//   o_sum     : result register, valid from Done until the next accept
//   o_cout    : final carry-out, same validity as o_sum
//   o_busy    : high in ADD and DONE
//   o_done    : one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module serial_add_controller
    import serial_add_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_busy,
    output logic         o_done
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_sum;
    logic [CW-1:0] r_count;
    logic          w_accept;
    logic          w_addPhase;
    logic          w_lastBit;
    logic          w_sumBit;
    logic          w_carry;

    assign w_addPhase = (r_state == ADD);
    assign w_lastBit  = (r_count == LAST);

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore outputs. The default arm catches the unused
    // encoding and sends it back to IDLE with Busy/Done low.
    always_comb begin
        w_nextState = IDLE;
        w_accept    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = ADD;
                end else begin
                    w_nextState = IDLE;
                end
            end
            ADD: begin
                o_busy      = 1'b1;
                w_nextState = w_lastBit ? DONE : ADD;
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: operands shift right so bit 0 always feeds the cell, and
    // each sum bit enters from the MSB so after N shifts it lands in place.
    // The counter returns to 0 on the last bit instead of wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_count <= '0;
        end else if (w_addPhase) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_sumBit, r_sum[N-1:1]};
            r_count <= w_lastBit ? '0 : r_count + CW'(1);
        end
    end

    // The carry flop only moves in ADD, so after the last bit it holds the
    // carry-out through DONE and IDLE until the next accept clears it.
    serial_add_cell u_cell (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_a      (r_a[0]),
        .i_b      (r_b[0]),
        .i_clear  (w_accept),
        .i_enable (w_addPhase),
        .o_s      (w_sumBit),
        .o_carry  (w_carry)
    );

    assign o_sum  = r_sum;
    assign o_cout = w_carry;

endmodule

// File: tb/tb_serial_add_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_add_controller
// Directed bench for serial_add_controller at N=8 and N=4. Expected results
// are computed from the operands and queued when a start is driven, then
// popped when Done is seen.
// ---------------------------------------------------------------------------
module tb_serial_add_controller;

    typedef struct packed {
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] opA;
    logic [7:0] opB;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    logic       start4;
    logic [3:0] opA4;
    logic [3:0] opB4;
    logic [3:0] sum4;
    logic       cout4;
    logic       busy4;
    logic       done4;

    int   compared;
    int   mismatched;
    int   cycle;
    int   acceptCycle;
    int   doneCycle;
    exp_t sbq[$];
    exp_t lastExp;

    serial_add_controller #(.N(8)) dut8 (
        .i_clock (clock),
        .i_reset (reset),
        .i_start (start),
        .i_a     (opA),
        .i_b     (opB),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_busy  (busy),
        .o_done  (done)
    );

    serial_add_controller #(.N(4)) dut4 (
        .i_clock (clock),
        .i_reset (reset),
        .i_start (start4),
        .i_a     (opA4),
        .i_b     (opB4),
        .o_sum   (sum4),
        .o_cout  (cout4),
        .o_busy  (busy4),
        .o_done  (done4)
    );

    // Free-running clock and an edge counter used to measure latency.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        cycle <= cycle + 1;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a start with operands, queue the reference result, and confirm
    // the edge was accepted.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input bit hold);
        exp_t e;
        logic [8:0] full;
        full   = {1'b0, a} + {1'b0, b};
        e.cout = full[8];
        e.sum  = full[7:0];
        start  = 1'b1;
        opA    = a;
        opB    = b;
        sbq.push_back(e);
        tick();
        acceptCycle = cycle;
        if (!hold) start = 1'b0;
        checkOutput("accept_busy", 32'(busy), 32'd1);
    endtask

    // Bounded wait for Done, then latency and scoreboard comparison.
    task automatic waitDone(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 40);
        doneCycle = cycle;
        checkOutput({tag, "_latency"}, 32'(cycle - acceptCycle), 32'd8);
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            lastExp = sbq.pop_front();
            checkOutput({tag, "_sum"}, 32'(sum), 32'(lastExp.sum));
            checkOutput({tag, "_cout"}, 32'(cout), 32'(lastExp.cout));
        end
    endtask

    initial begin
        logic [4:0] exp4;
        bit         sawDone;
        int         k;
        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        opA        = '0;
        opB        = '0;
        start4     = 1'b0;
        opA4       = '0;
        opB4       = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // 35 + 0A, then Done drops and the result holds in IDLE.
        applyStimulus(8'h35, 8'h0A, 1'b0);
        waitDone("add_35_0a");
        tick();
        checkOutput("done_pulse_end", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("idle_hold_sum", 32'(sum), 32'(lastExp.sum));

        // Start held high: FF+01 then FF+FF back to back. Operands for the
        // second add are changed during the first, which must not disturb it.
        applyStimulus(8'hFF, 8'h01, 1'b1);
        opA = 8'hFF;
        opB = 8'hFF;
        sbq.push_back(exp_t'{cout: 1'b1, sum: 8'hFE});
        waitDone("add_ff_01");
        k = doneCycle;
        tick();
        checkOutput("held_idle_busy", 32'(busy), 32'd0);
        tick();
        acceptCycle = cycle;
        start = 1'b0;
        checkOutput("held_accept_busy", 32'(busy), 32'd1);
        waitDone("add_ff_ff");
        checkOutput("held_done_gap", 32'(doneCycle - k), 32'd10);
        tick();

        // Start pulse mid-ADD with different operands is ignored.
        applyStimulus(8'h35, 8'h0A, 1'b0);
        tick();
        tick();
        start = 1'b1;
        opA   = 8'h11;
        opB   = 8'h22;
        tick();
        start = 1'b0;
        waitDone("ignore_mid_start");
        tick();

        // Reset in the 4th ADD cycle aborts without a Done pulse.
        applyStimulus(8'h35, 8'h0A, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sbq.pop_back());
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);

        // Fresh add after the abort.
        applyStimulus(8'h01, 8'h01, 1'b0);
        waitDone("add_01_01");
        tick();

        // A few random operand pairs.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'b0);
            waitDone("add_random");
            tick();
        end

        // Start and Reset on the same edge: stays IDLE.
        reset = 1'b1;
        start = 1'b1;
        opA   = 8'h55;
        opB   = 8'h66;
        tick();
        checkOutput("reset_start_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("reset_start_idle", 32'(busy), 32'd0);
        checkOutput("reset_start_done", 32'(done), 32'd0);

        // N=4 instance: A + 7.
        opA4   = 4'hA;
        opB4   = 4'h7;
        exp4   = {1'b0, opA4} + {1'b0, opB4};
        start4 = 1'b1;
        tick();
        acceptCycle = cycle;
        start4 = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done4 && k < 40);
        checkOutput("n4_latency", 32'(cycle - acceptCycle), 32'd4);
        checkOutput("n4_sum", 32'(sum4), 32'(exp4[3:0]));
        checkOutput("n4_cout", 32'(cout4), 32'(exp4[4]));
        tick();
        checkOutput("n4_done_end", 32'(done4), 32'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
